// File: rtl/poly_zeta_seq.sv
// ============================================================================
//  poly_zeta_seq : streams per-lane twiddle factors (zetas) for NTT, INTT and
//                  coefficient-wise multiply passes over a 128-butterfly layer.
//  Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module poly_zeta_seq #(
   parameter int NUM_PE = 2,
   parameter int ZW     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           mode,
   input  logic                 abort,
   output logic                 zeta_valid,
   input  logic                 zeta_ready,
   output logic [NUM_PE*ZW-1:0] zeta_data,
   output logic [2:0]           zeta_layer,
   output logic                 zeta_last,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [3:0] {
      MODE_NTT    = 4'd0,
      MODE_INTT   = 4'd1,
      MODE_CWM    = 4'd2,
      MODE_ADDSUB = 4'd3
   } pe_mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int          BPL       = 128 / NUM_PE;
   localparam logic [6:0]  LAST_BEAT = 7'(BPL - 1);
   localparam logic [11:0] Q         = 12'd3329;

   // Bit-reversed powers of 17 mod 3329; entry 0 is never addressed.
   localparam logic [11:0] ZETA_NTT_TABLE [128] = '{
      12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
      12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
      12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
      12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
      12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
      12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
      12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
      12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
      12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
      12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
      12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
      12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
      12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
      12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
      12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
      12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
   };

   // The multiply table pairs +z/-z of the upper half of the NTT table,
   // so it is derived rather than stored a second time.
   function automatic logic [11:0] zeta_lookup(input pe_mode_e   m,
                                               input logic [2:0] l,
                                               input logic [6:0] b);
      logic [6:0]  idx;
      logic [11:0] z;
      case (m)
         MODE_NTT:  idx = (7'd1 << l) + (b >> (3'd7 - l));
         MODE_INTT: idx = (7'd127 >> l) - (b >> (l + 3'd1));
         default:   idx = {1'b1, b[6:1]};
      endcase
      z = ZETA_NTT_TABLE[idx];
      if (m == MODE_CWM && b[0]) begin
         z = Q - z;
      end
      return z;
   endfunction

   state_e                state_q;
   pe_mode_e              mode_q;
   logic [6:0]            beat_q;
   logic [2:0]            layer_q;
   logic                  valid_q;
   logic [NUM_PE*ZW-1:0]  data_q;
   logic                  last_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;

   pe_mode_e              mode_d;
   logic [6:0]            beat_d;
   logic [2:0]            layer_d;
   logic [2:0]            final_layer_d;
   logic                  last_d;
   logic [NUM_PE*ZW-1:0]  data_d;
   logic                  legal_mode;
   logic                  layer_end;
   logic                  accept;

   assign legal_mode = (mode == MODE_NTT) || (mode == MODE_INTT) || (mode == MODE_CWM);
   assign layer_end  = (beat_q == LAST_BEAT);
   assign accept     = valid_q && zeta_ready;

   // Next-beat counters: from IDLE they describe beat 0 of the new sequence.
   always_comb begin
      mode_d  = mode_q;
      beat_d  = beat_q + 7'd1;
      layer_d = layer_q;
      if (state_q == S_IDLE) begin
         mode_d  = pe_mode_e'(mode);
         beat_d  = 7'd0;
         layer_d = 3'd0;
      end else if (layer_end) begin
         beat_d  = 7'd0;
         layer_d = layer_q + 3'd1;
      end
   end

   assign final_layer_d = (mode_d == MODE_CWM) ? 3'd0 : 3'd6;
   assign last_d        = (beat_d == LAST_BEAT) && (layer_d == final_layer_d);

   for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
      assign data_d[p*ZW +: ZW] = ZW'(zeta_lookup(mode_d, layer_d, beat_d * 7'(NUM_PE) + 7'(p)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_NTT;
         beat_q  <= 7'd0;
         layer_q <= 3'd0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (legal_mode) begin
                     state_q <= S_RUN;
                     mode_q  <= mode_d;
                     beat_q  <= beat_d;
                     layer_q <= layer_d;
                     valid_q <= 1'b1;
                     data_q  <= data_d;
                     last_q  <= last_d;
                     busy_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  beat_q  <= 7'd0;
                  layer_q <= 3'd0;
                  valid_q <= 1'b0;
                  data_q  <= '0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (accept) begin
                  if (last_q) begin
                     state_q <= S_DONE;
                     beat_q  <= 7'd0;
                     layer_q <= 3'd0;
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     beat_q  <= beat_d;
                     layer_q <= layer_d;
                     data_q  <= data_d;
                     last_q  <= last_d;
                  end
               end
            end
            S_DONE: begin
               // Abort here lands in the same place, so it needs no branch.
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign zeta_valid = valid_q;
   assign zeta_data  = data_q;
   assign zeta_layer = layer_q;
   assign zeta_last  = last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

`default_nettype wire
